// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shift/rotate unit iterating a single 1-bit stage with a start/busy/done handshake.
// Optional macro ITER_SHIFT_DOUBLE_STEP_EN applies two 1-bit steps per cycle while cnt >= 2.
module iter_shift_ctrl #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       op_r;

    logic [WIDTH-1:0] next_data;
    logic [AMT_W-1:0] next_cnt;
    logic             last_step;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] o);
        logic [WIDTH-1:0] r;
        unique case (o)
            2'b00:   r = {d[WIDTH-2:0], d[WIDTH-1]};
            2'b01:   r = {d[WIDTH-2:0], 1'b0};
            2'b10:   r = {d[0], d[WIDTH-1:1]};
            default: r = {1'b0, d[WIDTH-1:1]};
        endcase
        return r;
    endfunction

`ifdef ITER_SHIFT_DOUBLE_STEP_EN
    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        next_data = step(data, op_r);
        next_cnt  = cnt - AMT_W'(1);
        last_step = (cnt <= AMT_W'(2));
        if (cnt >= AMT_W'(2)) begin
            next_data = step(step(data, op_r), op_r);
            next_cnt  = cnt - AMT_W'(2);
        end
    end
`else
    always_comb begin
        next_data = step(data, op_r);
        next_cnt  = cnt - AMT_W'(1);
        last_step = (cnt == AMT_W'(1));
    end
`endif

    // busy and done are registered alongside the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            op_r  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        data <= in;
                        cnt  <= amt;
                        op_r <= op;
                        busy <= 1'b1;
                        if (amt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over the final step and leaves data at its partial value.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        data <= next_data;
                        cnt  <= next_cnt;
                        if (last_step) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result = data;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed bench for iter_shift_ctrl: expected results queued at start, checked on each done pulse.
module tb_iter_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] in;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int done_expect = 0;
    logic [15:0] sb[$];

    iter_shift_ctrl #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .in(in),
        .abort(abort), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) check("unexpected_done", {31'd0, done}, 32'd0);
            else check("result_at_done", {16'd0, result}, {16'd0, sb.pop_front()});
        end
    end

    function automatic int latency(input int n);
`ifdef ITER_SHIFT_DOUBLE_STEP_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    // glitch_k / abort_k / rst_k: cycle index after acceptance at which to act (-1 = never).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] a,
                          input logic [15:0] d, input logic [15:0] expv,
                          input int glitch_k, input int abort_k, input int rst_k);
        int  k;
        int  lat;
        bit  cancel;
        lat    = latency(int'(a));
        cancel = (abort_k >= 0) || (rst_k >= 0);
        if (!cancel) begin
            sb.push_back(expv);
            done_expect++;
        end
        @(negedge clk);
        start = 1'b1; op = o; amt = a; in = d;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); amt = 4'($urandom); in = 16'($urandom);
        check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
        k = 0;
        while (k <= 64) begin
            if (rst_k >= 0 && k == rst_k) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
                check({tag, "_rst_result"}, {16'd0, result}, 32'd0);
                break;
            end
            if (abort_k >= 0 && k == abort_k + 1) begin
                abort = 1'b0;
                check({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
                check({tag, "_abort_done"}, {31'd0, done}, 32'd0);
                break;
            end
            start = (k == glitch_k);
            if (k == glitch_k) in = 16'hFFFF;
            abort = (k == abort_k);
            if (done === 1'b1) break;
            @(negedge clk);
            k++;
        end
        if (k > 64) check({tag, "_timeout"}, 32'd1, 32'd0);
        if (!cancel) check({tag, "_latency"}, k, lat);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        if (!cancel) check({tag, "_idle_result"}, {16'd0, result}, {16'd0, expv});
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; amt = 4'd0; in = 16'h0000; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("rol_1",   2'b00, 4'd1,  16'h8001, 16'h0003, -1, -1, -1);
        run_op("sll_4",   2'b01, 4'd4,  16'h00FF, 16'h0FF0, -1, -1, -1);
        run_op("ror_15",  2'b10, 4'd15, 16'h0001, 16'h0002, -1, -1, -1);
        run_op("srl_15",  2'b11, 4'd15, 16'h8000, 16'h0001,  3, -1, -1);
        run_op("amt0",    2'b10, 4'd0,  16'hBEEF, 16'hBEEF,  0, -1, -1);
        run_op("rst_mid", 2'b00, 4'd8,  16'h1234, 16'h0000, -1, -1,  2);
        check("post_rst_result", {16'd0, result}, 32'd0);
        run_op("abort",   2'b00, 4'd8,  16'h1234, 16'h0000, -1,  2, -1);
        run_op("rol_8",   2'b00, 4'd8,  16'h1234, 16'h3412, -1, -1, -1);
        run_op("abort_last", 2'b01, 4'd5, 16'h0001, 16'h0000, -1, latency(5) - 1, -1);
        run_op("srl_7",   2'b11, 4'd7,  16'hF00F, 16'h01E0, -1, -1, -1);
        run_op("ror_4",   2'b10, 4'd4,  16'h00F1, 16'h100F, -1, -1, -1);
        run_op("sll_15",  2'b01, 4'd15, 16'h0001, 16'h8000, -1, -1, -1);
        run_op("rol_15",  2'b00, 4'd15, 16'hA5A5, 16'hD2D2, -1, -1, -1);

        check("done_pulse_count", done_seen, done_expect);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iter_shift_ctrl.md
Name: iter_shift_ctrl

Overview:
- Multi-cycle shifter controller built around a single 1-bit rotate/shift stage.
- Iterates the stage once per clock to perform a full variable-amount shift or rotate.
- Provides a start/busy/done handshake to the execute-stage control.
- Sits beside the ALU as a small-area alternative to a full barrel shifter; the execute-stage control stalls on busy.

Parameters:
WIDTH, 16, datapath width in bits; must equal 2**AMT_W
AMT_W, 4, shift-amount width in bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical
amt  input  AMT_W  shift amount, 0..WIDTH-1
in  input  WIDTH  operand
abort  input  1  synchronous cancel of an in-flight operation
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  contents of the internal data register

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; data register, count and op register cleared.
  - busy=0, done=0, result=0.
  - Reset mid-operation discards all work and produces no done pulse.
- State machine states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch in into data, amt into cnt, op into op_r.
  - If amt==0, go to DONE; otherwise go to RUN.
  - start=0 keeps IDLE; data is held.
- RUN, each cycle:
  - data <= step(data, op_r); cnt <= cnt-1.
  - When cnt==1 this is the final step; go to DONE.
- DONE:
  - done=1 for exactly this cycle; go to IDLE.
  - result is valid in DONE and stays stable in IDLE until the next accepted start.
- Step functions, all over WIDTH bits:
  - Rotate left: {d[W-2:0], d[W-1]}.
  - Shift left logical: {d[W-2:0], 1'b0}.
  - Rotate right: {d[0], d[W-1:1]}.
  - Shift right logical: {1'b0, d[W-1:1]}.
- Latency:
  - Start accepted at edge T.
  - For amt=N>0, done is high in the cycle after edge T+N.
  - For amt=0, done is high in the cycle after edge T, with result=in.
  - busy is high from the cycle after edge T until done inclusive.
- Start while busy=1, including in DONE, is ignored. No queueing; in/op/amt changes have no effect.
- Abort:
  - abort=1 in RUN: go to IDLE next edge, no done pulse, data holds its partial value (not valid).
  - abort in IDLE or DONE is ignored.
  - If abort and the final RUN step coincide, abort wins.
- result changes only on a step or an accepted start. Intermediate values are visible during RUN but are not valid.
- cnt never underflows: RUN is never entered with cnt==0.

Optional Feature:
- Macro: ITER_SHIFT_DOUBLE_STEP_EN.
- When defined:
  - RUN applies two 1-bit steps per cycle (step(step(d))) while cnt>=2, decrementing cnt by 2.
  - It applies a single step when cnt==1.
  - Latency is ceil(N/2) RUN cycles, so done is in the cycle after edge T+ceil(N/2).
  - Final results are identical to single-step mode.
- When undefined: exactly one step per cycle, as above.

Test Plan:
- Rotate left, in=0x8001, amt=1 -> result=0x0003; done in the cycle after T+1; busy high for 2 cycles.
- Shift left logical, in=0x00FF, amt=4 -> result=0x0FF0; done after T+4. Under ITER_SHIFT_DOUBLE_STEP_EN, done after T+2.
- Rotate right, in=0x0001, amt=15 -> result=0x0002; done after T+15 (after T+8 with the macro).
- Shift right logical, in=0x8000, amt=15 -> result=0x0001. A second start pulsed at T+3 with in=0xFFFF is ignored; result is unchanged; exactly one done pulse.
- amt=0, in=0xBEEF, any op -> done in the cycle after T, result=0xBEEF. A follow-up start during DONE is ignored.
- Reset and abort: rotate left in=0x1234 amt=8, rst asserted at T+3 -> busy=0, done=0, result=0 immediately with no clock edge. Separately, abort at T+3 -> IDLE next edge, no done pulse; a new start then completes normally.
